// File: rtl/softmax_replay_fifo_pkg.sv
// Shared types and helpers for the softmax replay FIFO.
// Pointer distance and mark/release/rewind priority decode.
package softmax_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    CTL_NONE    = 2'd0,
    CTL_MARK    = 2'd1,
    CTL_RELEASE = 2'd2,
    CTL_REWIND  = 2'd3
  } ctl_e;

  // Wrap-aware a - b over pw-bit pointers.
  function automatic logic [31:0] ptr_dist(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned pw
  );
    return (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction

  function automatic ctl_e ctl_decode(
    input logic rw,
    input logic rl,
    input logic mk
  );
    if (rw)      return CTL_REWIND;
    else if (rl) return CTL_RELEASE;
    else if (mk) return CTL_MARK;
    else         return CTL_NONE;
  endfunction

endpackage

// File: rtl/softmax_replay_fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// The read register clears synchronously; the array is never reset.
module sdp_ram #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rd_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_clr)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/softmax_replay_fifo.sv
// Softmax score FIFO with status flags, sticky errors and
// mark/rewind replay so a vector can be re-read several times.
module softmax_replay_fifo
  import softmax_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = 16,
  parameter  int AF_THRESH  = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  input  logic                  i_mark,
  input  logic                  i_release,
  input  logic                  i_rewind,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_mark_ptr;
  logic          r_mark_active;
  logic          r_rd_valid;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_base;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_used;
  logic [PW-1:0] w_free;
  logic          w_full;
  logic          w_empty;
  logic          w_rew;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_rst;
  ctl_e          w_ctl;

  assign w_rst   = !i_rst_n || i_clr;
  assign w_base  = r_mark_active ? r_mark_ptr : r_rd_ptr;
  assign w_count = PW'(ptr_dist(32'(r_wr_ptr), 32'(r_rd_ptr), PW));
  assign w_used  = PW'(ptr_dist(32'(r_wr_ptr), 32'(w_base), PW));
  assign w_free  = PW'(DEPTH) - w_used;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_used == PW'(DEPTH));

  // Only an armed rewind steals the read slot.
  assign w_rew    = i_rewind && r_mark_active;
  assign w_wr_acc = i_wr_en && !w_full;
  assign w_rd_acc = i_rd_en && !w_empty && !w_rew;
  assign w_ctl    = ctl_decode(i_rewind, i_release, i_mark);

  sdp_ram #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rd_clr (w_rst),
    .i_we     (w_wr_acc && !w_rst),
    .i_waddr  (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata  (i_wr_data),
    .i_re     (w_rd_acc),
    .i_raddr  (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata  (o_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mark_ptr    <= '0;
      r_mark_active <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_wr_en && w_full) r_ovf <= 1'b1;
      if (i_rd_en && w_empty && !w_rew) r_unf <= 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_rd_valid <= w_rd_acc;
      unique case (w_ctl)
        CTL_REWIND: begin
          if (r_mark_active) r_rd_ptr <= r_mark_ptr;
        end
        CTL_RELEASE: r_mark_active <= 1'b0;
        CTL_MARK: begin
          r_mark_ptr    <= r_rd_ptr;
          r_mark_active <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_full        = w_full;
  assign o_almost_full = (w_free <= PW'(AF_THRESH));
  assign o_empty       = w_empty;
  assign o_count       = w_count;
  assign o_rd_valid    = r_rd_valid;
  assign o_overflow    = r_ovf;
  assign o_underflow   = r_unf;

endmodule
